mmu_controller: RTL

//  Sequences one matrix multiply C[M x N] = A[M x K] * B[K x N] through the systolic MMU.

---
 rtl/mmu_controller.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mmu_controller.sv
// Sequences one C = A*B job through the systolic MMU: weights, activations,
// result-row writes into the output FIFO, then buffer clears.
module mmu_controller #(
  parameter int MMU_SIZE = 10,
  parameter int PIPE_LAT = 2 * MMU_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dim_m,
  input  logic [7:0] dim_k,
  input  logic [7:0] dim_n,
  input  logic       fifo_empty,
  output logic       busy,
  output logic       done,
  output logic       cfg_error,
  output logic [1:0] buffer_a_cmd,
  output logic [1:0] buffer_b_cmd,
  output logic       mmu_load_weights,
  output logic       mmu_valid,
  output logic       fifo_wr,
  output logic       fifo_dim_wr,
  output logic [7:0] dim_x_out,
  output logic [7:0] dim_y_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_PEND, S_WEIGHTS, S_RUN, S_DONE
  } state_t;

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_SEND  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam logic [7:0] W_MAX = 8'(MMU_SIZE);
  localparam logic [15:0] W_WLAST = 16'(MMU_SIZE - 1);
  localparam logic [15:0] W_PL = 16'(PIPE_LAT);

  state_t      r_state;
  state_t      w_state_n;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_n;
  logic [7:0]  w_dim_x_n;
  logic [7:0]  w_dim_y_n;
  logic        w_cfg_err_n;
  logic        w_illegal;
  logic [15:0] w_m16;
  logic [15:0] w_run_last;
  logic [1:0]  w_a_cmd_n;
  logic [1:0]  w_b_cmd_n;
  logic        w_in_run;

  assign w_illegal = (dim_m == 8'd0) || (dim_m > W_MAX) ||
                     (dim_k == 8'd0) || (dim_k > W_MAX) ||
                     (dim_n == 8'd0) || (dim_n > W_MAX);

  assign w_run_last = W_PL + {8'd0, dim_x_out} - 16'd1;

  always_comb begin
    w_state_n   = r_state;
    w_dim_x_n   = dim_x_out;
    w_dim_y_n   = dim_y_out;
    w_cfg_err_n = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_illegal) begin
            w_cfg_err_n = 1'b1;
          end else begin
            w_dim_x_n = dim_m;
            w_dim_y_n = dim_n;
            w_state_n = fifo_empty ? S_WEIGHTS : S_PEND;
          end
        end
      end
      S_PEND:    if (fifo_empty) w_state_n = S_WEIGHTS;
      S_WEIGHTS: if (r_cnt == W_WLAST) w_state_n = S_RUN;
      S_RUN:     if (r_cnt == w_run_last) w_state_n = S_DONE;
      S_DONE:    w_state_n = S_IDLE;
      default:   w_state_n = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state/count.
  always_comb begin
    w_cnt_n = r_cnt + 16'd1;
    if (w_state_n != r_state || w_state_n == S_IDLE ||
        w_state_n == S_PEND)
      w_cnt_n = 16'd0;
  end

  assign w_m16    = {8'd0, w_dim_x_n};
  assign w_in_run = (w_state_n == S_RUN);

  always_comb begin
    w_a_cmd_n = CMD_NONE;
    w_b_cmd_n = CMD_NONE;
    unique case (1'b1)
      w_state_n == S_DONE: begin
        w_a_cmd_n = CMD_CLEAR;
        w_b_cmd_n = CMD_CLEAR;
      end
      w_in_run && w_cnt_n == 16'd0:
        w_a_cmd_n = CMD_SEND;
      w_state_n == S_WEIGHTS && w_cnt_n == 16'd0:
        w_b_cmd_n = CMD_SEND;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_cnt            <= 16'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cfg_error        <= 1'b0;
      buffer_a_cmd     <= CMD_NONE;
      buffer_b_cmd     <= CMD_NONE;
      mmu_load_weights <= 1'b0;
      mmu_valid        <= 1'b0;
      fifo_wr          <= 1'b0;
      fifo_dim_wr      <= 1'b0;
      dim_x_out        <= 8'd0;
      dim_y_out        <= 8'd0;
    end else begin
      r_state          <= w_state_n;
      r_cnt            <= w_cnt_n;
      busy             <= (w_state_n != S_IDLE);
      done             <= (w_state_n == S_DONE);
      cfg_error        <= w_cfg_err_n;
      buffer_a_cmd     <= w_a_cmd_n;
      buffer_b_cmd     <= w_b_cmd_n;
      mmu_load_weights <= (w_state_n == S_WEIGHTS);
      mmu_valid        <= w_in_run && (w_cnt_n < w_m16);
      fifo_wr          <= w_in_run && (w_cnt_n >= W_PL) &&
                          (w_cnt_n < W_PL + w_m16);
      fifo_dim_wr      <= w_in_run && (w_cnt_n == W_PL);
      dim_x_out        <= w_dim_x_n;
      dim_y_out        <= w_dim_y_n;
    end
  end

endmodule
